mem_port_arbiter: RTL and testbench

- Shares one single-port `memory` instance between the pipe's instruction-fetch port and its data read/write ports, for unified-memory builds.
- Sits between `pipe` and the memory: it sequences accesses, drives the memory's word-address, ready and byte-enable pins, and returns the `*_valid` handshakes the pipe already consumes.
- Fixed priority is data write > data read > fetch, with a starvation guard that periodically forces a fetch grant.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/arb_priority_sel.sv | 32 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : state encoding, grant indices, default parameters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2,
    D_WR  = 2'd3
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STREAK_W_DEF     = 3;

  // Bit positions within the one-hot grant vector.
  localparam int GNT_W  = 3;
  localparam int GNT_IF = 0;
  localparam int GNT_RD = 1;
  localparam int GNT_WR = 2;

endpackage

`default_nettype wire

// File: rtl/arb_priority_sel.sv
// ---------------------------------------------------------------------------
// arb_priority_sel : one-hot grant encoder, forced fetch > write > read > fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_priority_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic             if_req,
  input  logic             d_rd_req,
  input  logic             d_wr_req,
  input  logic             force_if,
  output logic [GNT_W-1:0] grant
);

  always_comb begin
    grant = '0;
    if (force_if) begin
      grant[GNT_IF] = 1'b1;
    end else if (d_wr_req) begin
      grant[GNT_WR] = 1'b1;
    end else if (d_rd_req) begin
      grant[GNT_RD] = 1'b1;
    end else if (if_req) begin
      grant[GNT_IF] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one single-port memory between fetch and data ports
// Optional perf counters under MEM_PORT_ARB_PERF_EN.              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int STREAK_W     = STREAK_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  output logic [31:0] d_rdata,
  output logic        d_rd_valid,
  input  logic        d_wr_req,
  input  logic [31:0] d_wr_addr,
  input  logic [31:0] d_wr_data,
  input  logic [3:0]  d_wr_byte,
  output logic        d_wr_valid,
  output logic        mem_read_ready,
  output logic [29:0] mem_read_address,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_ready,
  output logic [29:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte,
  output logic        busy
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_data_grants
`endif
);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic [GNT_W-1:0]    grant;
  logic                idle_act;
  logic                force_if;
  logic                gnt_if;
  logic                gnt_rd;
  logic                gnt_wr;
  logic                data_gnt;
  logic                streak_full;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_rd_addr[1:0], d_wr_addr[1:0]};

  // Grants are only issued from IDLE and never while reset is held.
  assign idle_act    = reset && (state == IDLE);
  assign streak_full = (streak == STREAK_W'(STARVE_LIMIT));
  assign force_if    = if_req && streak_full;

  arb_priority_sel u_sel (
    .if_req   (if_req),
    .d_rd_req (d_rd_req),
    .d_wr_req (d_wr_req),
    .force_if (force_if),
    .grant    (grant)
  );

  assign gnt_if   = idle_act && grant[GNT_IF];
  assign gnt_rd   = idle_act && grant[GNT_RD];
  assign gnt_wr   = idle_act && grant[GNT_WR];
  assign data_gnt = gnt_rd || gnt_wr;

  always_comb begin
    mem_read_ready    = gnt_if || gnt_rd;
    mem_read_address  = '0;
    if (gnt_if) begin
      mem_read_address = if_addr[31:2];
    end else if (gnt_rd) begin
      mem_read_address = d_rd_addr[31:2];
    end
    mem_write_ready   = gnt_wr;
    mem_write_address = gnt_wr ? d_wr_addr[31:2] : '0;
    mem_write_data    = gnt_wr ? d_wr_data       : '0;
    mem_write_byte    = gnt_wr ? d_wr_byte       : '0;
  end

  // Completion pulses follow the registered state; reset masks a pending one.
  always_comb begin
    if_valid   = reset && (state == IF_RD);
    d_rd_valid = reset && (state == D_RD);
    d_wr_valid = reset && (state == D_WR);
    busy       = reset && (state != IDLE);
    if_rdata   = if_valid   ? mem_read_data : '0;
    d_rdata    = d_rd_valid ? mem_read_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_if) begin
            state <= IF_RD;
          end else if (gnt_wr) begin
            state <= D_WR;
          end else if (gnt_rd) begin
            state <= D_RD;
          end
          if (!if_req || gnt_if) begin
            streak <= '0;
          end else if (data_gnt && !streak_full) begin
            streak <= streak + STREAK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_if_stall    <= '0;
      perf_data_grants <= '0;
    end else begin
      if (if_req && !gnt_if && (state != IF_RD)) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (data_gnt) begin
        perf_data_grants <= perf_data_grants + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + random bench with transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_rd_req, d_wr_req;
  logic [31:0] if_addr, d_rd_addr, d_wr_addr, d_wr_data;
  logic [3:0]  d_wr_byte;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, d_rd_valid, d_wr_valid;
  logic        mem_read_ready, mem_write_ready, busy;
  logic [29:0] mem_read_address, mem_write_address;
  logic [31:0] mem_read_data = '0;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_stall, perf_data_grants;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .STREAK_W(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rdata(d_rdata), .d_rd_valid(d_rd_valid),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_byte(d_wr_byte), .d_wr_valid(d_wr_valid),
    .mem_read_ready(mem_read_ready), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data),
    .mem_write_ready(mem_write_ready), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_byte(mem_write_byte),
    .busy(busy)
`ifdef MEM_PORT_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_data_grants(perf_data_grants)
`endif
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Memory device seen by the DUT (64 words, address aliased on [5:0]).
  logic [31:0] dev_mem [64];
  logic [31:0] ref_mem [64];

  always @(posedge clk) begin
    if (mem_write_ready)
      dev_mem[mem_write_address[5:0]] <= merge(dev_mem[mem_write_address[5:0]],
                                               mem_write_data, mem_write_byte);
    if (mem_read_ready) mem_read_data <= dev_mem[mem_read_address[5:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: who is served and what each cycle should show.
  int          m_kind = 0;   // 0 free, 1 fetch, 2 data read, 3 data write in flight
  int          m_cnt  = 0;   // consecutive data grants while fetch waits
  logic [5:0]  m_addr = '0;
  int unsigned m_stall = 0, m_dgr = 0;
  bit          perf_ok = 0;
  int          done_q[$];

  logic        obs_rr, obs_ifv, obs_drv, obs_dwv, obs_busy;
  logic [29:0] obs_ra;
  logic [31:0] obs_ifd, obs_drd;

  task automatic preload(input int idx, input logic [31:0] v);
    dev_mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic step();
    int g;
    logic        e_rr, e_wr, e_ifv, e_drv, e_dwv, e_busy;
    logic [29:0] e_ra, e_wa;
    logic [31:0] e_wd, e_ifd, e_drd;
    logic [3:0]  e_wb;
    @(negedge clk);
    g = 0;
    {e_rr, e_wr, e_ifv, e_drv, e_dwv, e_busy} = '0;
    e_ra = '0; e_wa = '0; e_wd = '0; e_ifd = '0; e_drd = '0; e_wb = '0;
    if (reset) begin
      if (m_kind == 0) begin
        if (if_req && m_cnt == LIMIT) g = 1;
        else if (d_wr_req)            g = 3;
        else if (d_rd_req)            g = 2;
        else if (if_req)              g = 1;
        e_rr = (g == 1) || (g == 2);
        e_ra = (g == 1) ? if_addr[31:2] : (g == 2) ? d_rd_addr[31:2] : 30'd0;
        if (g == 3) begin
          e_wr = 1'b1; e_wa = d_wr_addr[31:2]; e_wd = d_wr_data; e_wb = d_wr_byte;
        end
      end else begin
        e_busy = 1'b1;
        e_ifv  = (m_kind == 1);
        e_drv  = (m_kind == 2);
        e_dwv  = (m_kind == 3);
        if (e_ifv) e_ifd = ref_mem[m_addr];
        if (e_drv) e_drd = ref_mem[m_addr];
      end
    end
    check_val("rd_ready", 32'(mem_read_ready), 32'(e_rr));
    check_val("rd_addr",  32'(mem_read_address), 32'(e_ra));
    check_val("wr_ready", 32'(mem_write_ready), 32'(e_wr));
    check_val("wr_addr",  32'(mem_write_address), 32'(e_wa));
    check_val("wr_data",  mem_write_data, e_wd);
    check_val("wr_byte",  32'(mem_write_byte), 32'(e_wb));
    check_val("if_valid", 32'(if_valid), 32'(e_ifv));
    check_val("if_rdata", if_rdata, e_ifd);
    check_val("d_rd_valid", 32'(d_rd_valid), 32'(e_drv));
    check_val("d_rdata",  d_rdata, e_drd);
    check_val("d_wr_valid", 32'(d_wr_valid), 32'(e_dwv));
    check_val("busy",     32'(busy), 32'(e_busy));
`ifdef MEM_PORT_ARB_PERF_EN
    if (reset && perf_ok) begin
      check_val("perf_if_stall", perf_if_stall, m_stall);
      check_val("perf_data_grants", perf_data_grants, m_dgr);
    end
`endif
    obs_rr = mem_read_ready; obs_ra = mem_read_address; obs_busy = busy;
    obs_ifv = if_valid; obs_ifd = if_rdata; obs_drv = d_rd_valid; obs_drd = d_rdata;
    obs_dwv = d_wr_valid;
    if (if_valid)   done_q.push_back(1);
    if (d_rd_valid) done_q.push_back(2);
    if (d_wr_valid) done_q.push_back(3);
    if (!reset) begin
      m_kind = 0; m_cnt = 0; m_stall = 0; m_dgr = 0; perf_ok = 1;
    end else if (m_kind == 0) begin
      if (g == 1 || !if_req)          m_cnt = 0;
      else if (g >= 2 && m_cnt < LIMIT) m_cnt++;
      if (g >= 2) m_dgr++;
      if (if_req && g != 1) m_stall++;
      if (g == 3) ref_mem[d_wr_addr[7:2]] = merge(ref_mem[d_wr_addr[7:2]], d_wr_data, d_wr_byte);
      m_addr = (g == 1) ? if_addr[7:2] : d_rd_addr[7:2];
      m_kind = g;
    end else begin
      if (if_req && m_kind != 1) m_stall++;
      m_kind = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    if_req = 0; d_rd_req = 0; d_wr_req = 0;
  endtask

  task automatic check_starve(input string tag);
    int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    check_val({tag, "_len"}, 32'(done_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < done_q.size(); i++)
      check_val($sformatf("%s_%0d", tag, i), 32'(done_q[i]), 32'(exp_seq[i]));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    reset = 0;
    if_req = 1; d_rd_req = 1; d_wr_req = 1;
    if_addr = 32'h10; d_rd_addr = 32'h20; d_wr_addr = 32'h30;
    d_wr_data = 32'h1234_5678; d_wr_byte = 4'hF;
    step(); step();
    check_val("reset_rd_ready", 32'(obs_rr), 32'd0);
    check_val("reset_busy", 32'(obs_busy), 32'd0);
    reset = 1; idle_reqs();
    step();

    // Fetch only
    preload(4, 32'h0000_0013);
    if_req = 1; if_addr = 32'h0000_0010;
    step();
    check_val("fetch_addr", 32'(obs_ra), 32'd4);
    check_val("fetch_busy_c0", 32'(obs_busy), 32'd0);
    step();
    check_val("fetch_valid", 32'(obs_ifv), 32'd1);
    check_val("fetch_data", obs_ifd, 32'h0000_0013);
    check_val("fetch_busy_c1", 32'(obs_busy), 32'd1);
    idle_reqs(); step();

    // Write then read same address
    d_wr_req = 1; d_rd_req = 1; d_wr_addr = 32'h40; d_rd_addr = 32'h40;
    d_wr_data = 32'hDEAD_BEEF; d_wr_byte = 4'hF;
    step();
    check_val("wr_first_no_rd", 32'(obs_rr), 32'd0);
    step();
    check_val("wr_valid_c1", 32'(obs_dwv), 32'd1);
    d_wr_req = 0;
    step();
    check_val("rd_issue_c2", 32'(obs_rr), 32'd1);
    step();
    check_val("rd_valid_c3", 32'(obs_drv), 32'd1);
    check_val("rd_data_c3", obs_drd, 32'hDEAD_BEEF);
    idle_reqs(); step();

    // Byte-enable write
    preload(32'h20, 32'h1122_3344);
    d_wr_req = 1; d_wr_addr = 32'h80; d_wr_data = 32'hAABB_CCDD; d_wr_byte = 4'b0101;
    step(); step();
    d_wr_req = 0; d_rd_req = 1; d_rd_addr = 32'h83;
    step(); step();
    check_val("be_rdata", obs_drd, 32'h11BB_33DD);
    idle_reqs(); step();

    // Starvation guard
    done_q.delete();
    if_req = 1; d_rd_req = 1; if_addr = 32'h14; d_rd_addr = 32'h24;
    for (int i = 0; i < 20; i++) step();
    check_starve("starve");
    idle_reqs(); step();

    // Reset mid-read, then the streak must restart from zero
    if_req = 1; d_rd_req = 1;
    for (int i = 0; i < 5; i++) step();
    reset = 0;
    step();
    check_val("rst_no_rd_valid", 32'(obs_drv), 32'd0);
    reset = 1; idle_reqs();
    step();
    check_val("rst_after_busy", 32'(obs_busy), 32'd0);
    check_val("rst_after_rd_valid", 32'(obs_drv), 32'd0);
    done_q.delete();
    if_req = 1; d_rd_req = 1;
    for (int i = 0; i < 20; i++) step();
    check_starve("post_rst");
    idle_reqs(); step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 59) != 0);
      if_req    = 1'($urandom_range(0, 1));
      d_rd_req  = 1'($urandom_range(0, 2) == 0);
      d_wr_req  = 1'($urandom_range(0, 3) == 0);
      if_addr   = $urandom;
      d_rd_addr = $urandom;
      d_wr_addr = $urandom;
      d_wr_data = $urandom;
      d_wr_byte = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
